// File: rtl/wb_stage_pkg.sv
// Shared constants and FSM encoding for the write-back stage.
package wb_stage_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int REG_CNT_DEFAULT = 15;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_mux.sv
// Result selector and destination-range check for the write-back stage.
module wb_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 15
) (
  input  logic              sel_load,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [3:0]        dest,
  input  logic              wr_en,
  output logic [DATA_W-1:0] value,
  output logic              eff_en,
  output logic              drop
);

  logic dest_ok;

  // Indices at or above REG_CNT (the PC) are never written to the register file.
  assign dest_ok = ({28'd0, dest} < REG_CNT);
  assign value   = sel_load ? ld_data : alu_res;
  assign eff_en  = wr_en & dest_ok;
  assign drop    = wr_en & ~dest_ok;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires MEM-stage instructions onto the register-file write port.
// Optional retirement counter enabled by `WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W  = ADDRESS_LEN,
  parameter int REG_CNT = REG_CNT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [3:0]        mem_dest,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              stall,
  output logic              wb_en,
  output logic [3:0]        wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              drop_pulse
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  wb_state_e         state_q, state_d;
  logic [3:0]        hold_dest_q, hold_dest_d;
  logic              hold_en_q, hold_en_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;
  logic              drop_q, drop_d;

  logic              retire;
  logic              sel_load;
  logic [3:0]        cur_dest;
  logic              cur_en;
  logic [DATA_W-1:0] sel_value;
  logic              eff_en;
  logic              drop;

  wb_mux #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT)
  ) u_mux (
    .sel_load(sel_load),
    .alu_res (alu_res),
    .ld_data (ld_data),
    .dest    (cur_dest),
    .wr_en   (cur_en),
    .value   (sel_value),
    .eff_en  (eff_en),
    .drop    (drop)
  );

  always_comb begin
    state_d     = state_q;
    hold_dest_d = hold_dest_q;
    hold_en_d   = hold_en_q;
    retire      = 1'b0;
    stall       = 1'b0;
    sel_load    = 1'b1;
    cur_dest    = hold_dest_q;
    cur_en      = hold_en_q;
    case (state_q)
      WB_IDLE: begin
        sel_load = mem_r_en;
        cur_dest = mem_dest;
        cur_en   = mem_wb_en;
        if (mem_valid) begin
          if (!mem_r_en || ld_valid) begin
            retire = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = WB_WAIT_LD;
            hold_dest_d = mem_dest;
            hold_en_d   = mem_wb_en;
          end
        end
      end
      // Only the load-return handshake matters here; the MEM stage is frozen.
      WB_WAIT_LD: begin
        if (ld_valid) begin
          retire  = 1'b1;
          state_d = WB_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    wb_en_d    = retire & eff_en;
    drop_d     = retire & drop;
    wb_dest_d  = retire ? cur_dest : wb_dest_q;
    wb_value_d = retire ? sel_value : wb_value_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WB_IDLE;
      hold_dest_q <= '0;
      hold_en_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_value_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_dest_q <= hold_dest_d;
      hold_en_q   <= hold_en_d;
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_value_q  <= wb_value_d;
      drop_q      <= drop_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_dest    = wb_dest_q;
  assign wb_value   = wb_value_q;
  assign drop_pulse = drop_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Every retirement counts, including suppressed and non-writing ones.
  always_comb begin
    retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retire_cnt_q <= '0;
    else      retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
